// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, encodings and helpers for mem_arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 3;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [DATA_W-1:0] ZERO      = '0;
    localparam logic [BYTE_W-1:0] ZERO_BYTE = '0;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]  N_WORD    = 3'd4;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_LS = 1'b0,
        OWN_IF = 1'b1
    } owner_t;

    function automatic logic [CNT_W-1:0] size_to_n(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_ram_byte_seq.sv
// rtl/mem_arbiter_ram_byte_seq.sv - byte counter, RAM address, write-lane select and read assembly
module mem_arbiter_ram_byte_seq
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_capture,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BYTE_W-1:0] i_din,
    output logic [CNT_W-1:0]  o_k,
    output logic [ADDR_W-1:0] o_addr,
    output logic [BYTE_W-1:0] o_dout,
    output logic [DATA_W-1:0] o_word_next
);

    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_k;
    logic [DATA_W-1:0] r_rbuf;
    logic [1:0]        w_cap_idx;

    // RAM data lags its address by one cycle, so the byte arriving now belongs to k-1.
    assign w_cap_idx = r_k[1:0] - 2'd1;

    assign o_k    = r_k;
    assign o_addr = r_base + {{(ADDR_W-CNT_W){1'b0}}, r_k};
    assign o_dout = r_wdata[{r_k[1:0], 3'b000} +: BYTE_W];

    always_comb begin
        o_word_next = r_rbuf;
        if (i_capture) begin
            o_word_next[{w_cap_idx, 3'b000} +: BYTE_W] = i_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base  <= '0;
            r_wdata <= '0;
            r_k     <= CNT_ZERO;
            r_rbuf  <= ZERO;
        end else if (i_en) begin
            if (i_load) begin
                r_base  <= i_base;
                r_wdata <= i_wdata;
                r_k     <= CNT_ZERO;
                r_rbuf  <= ZERO;
            end else begin
                if (i_step) begin
                    r_k <= r_k + CNT_W'(1);
                end
                if (i_capture) begin
                    r_rbuf <= o_word_next;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-wide RAM port arbiter between fetch and load/store buffer
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [BYTE_W-1:0] ram_dout,
    input  logic [BYTE_W-1:0] ram_din
);

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    state_t            r_state;
    state_t            w_state_next;
    owner_t            r_owner;
    logic [CNT_W-1:0]  r_n;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_ls_rdata;

    logic              w_grant_if;
    logic              w_grant_ls;
    logic              w_grant;
    logic              w_force_if;
    logic              w_step;
    logic              w_capture;
    logic              w_load_data;
    logic [CNT_W-1:0]  w_k;
    logic [ADDR_W-1:0] w_addr;
    logic [BYTE_W-1:0] w_dout;
    logic [DATA_W-1:0] w_word_next;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] r_starve;

    assign w_force_if = (r_starve == STARVE_W'(STARVE_LIMIT)) && if_req && !if_flush;

    // Saturates so a flush-blocked forced grant keeps forcing once the flush drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (rdy) begin
            if (w_grant_if) begin
                r_starve <= '0;
            end else if (w_grant_ls && if_req && (r_starve != STARVE_W'(STARVE_LIMIT))) begin
                r_starve <= r_starve + STARVE_W'(1);
            end
        end
    end
`else
    assign w_force_if = FALSE;
`endif

    always_comb begin
        w_state_next = r_state;
        w_grant_if   = FALSE;
        w_grant_ls   = FALSE;
        w_step       = FALSE;
        w_capture    = FALSE;
        w_load_data  = FALSE;
        case (r_state)
            S_IDLE: begin
                if (w_force_if) begin
                    w_grant_if   = TRUE;
                    w_state_next = S_READ;
                end else if (ls_req) begin
                    w_grant_ls   = TRUE;
                    w_state_next = ls_wr ? S_WRITE : S_READ;
                end else if (if_req && !if_flush) begin
                    w_grant_if   = TRUE;
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                if ((r_owner == OWN_IF) && if_flush) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_step    = (w_k < r_n);
                    w_capture = (w_k != CNT_ZERO);
                    if (w_k == r_n) begin
                        w_load_data  = TRUE;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                w_step = TRUE;
                if (w_k == (r_n - CNT_W'(1))) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_grant = w_grant_if | w_grant_ls;

    mem_arbiter_ram_byte_seq u_seq (
        .clk         (clk),
        .rst         (rst),
        .i_en        (rdy),
        .i_load      (w_grant),
        .i_step      (w_step),
        .i_capture   (w_capture),
        .i_base      (w_grant_if ? if_addr : ls_addr),
        .i_wdata     (ls_wdata),
        .i_din       (ram_din),
        .o_k         (w_k),
        .o_addr      (w_addr),
        .o_dout      (w_dout),
        .o_word_next (w_word_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_owner    <= OWN_LS;
            r_n        <= CNT_ZERO;
            r_if_data  <= ZERO;
            r_ls_rdata <= ZERO;
        end else if (rdy) begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_owner <= w_grant_if ? OWN_IF : OWN_LS;
                r_n     <= w_grant_if ? N_WORD : size_to_n(ls_size);
            end
            // Final byte is merged combinationally so data lands together with DONE.
            if (w_load_data) begin
                if (r_owner == OWN_IF) begin
                    r_if_data <= w_word_next;
                end else begin
                    r_ls_rdata <= w_word_next;
                end
            end
        end
    end

    assign if_valid = (r_state == S_DONE) && (r_owner == OWN_IF);
    assign ls_valid = (r_state == S_DONE) && (r_owner == OWN_LS);
    assign if_data  = r_if_data;
    assign ls_rdata = r_ls_rdata;
    assign ram_wr   = (r_state == S_WRITE);
    assign ram_addr = w_addr;
    assign ram_dout = (r_state == S_WRITE) ? w_dout : ZERO_BYTE;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a byte RAM model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_valid;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_valid;
    logic [31:0] ls_rdata;
    logic        ram_wr;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    logic [7:0]  mem [0:65535];
    logic        tb_we;
    logic [15:0] tb_addr;
    logic [7:0]  tb_data;

    typedef struct {
        bit          is_if;
        bit          chk_data;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_ls;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_valid (if_valid),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_wr    (ls_wr),
        .ls_size  (ls_size),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_valid (ls_valid),
        .ls_rdata (ls_rdata),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .ram_din  (ram_din)
    );

    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (rdy && ram_wr) begin
            mem[ram_addr[15:0]] <= ram_dout;
        end
        if (rdy) begin
            ram_din <= mem[ram_addr[15:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(posedge clk);
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic push_exp(input bit is_if, input bit chk, input logic [31:0] d, input int lat);
        exp_t e;
        e.is_if    = is_if;
        e.chk_data = chk;
        e.data     = d;
        e.lat      = lat;
        sb.push_back(e);
    endtask

    task automatic start_ls(input bit wr, input logic [1:0] size, input logic [31:0] a,
                            input logic [31:0] wd);
        ls_wr    = wr;
        ls_size  = size;
        ls_addr  = a;
        ls_wdata = wd;
        ls_req   = 1'b1;
    endtask

    task automatic wait_check(input string tag, input int budget);
        int   edges;
        bit   got;
        exp_t e;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < budget) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            got = if_valid || ls_valid;
        end
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: scoreboard empty, observed valid %0d expected an entry", tag, got);
        end else begin
            e = sb.pop_front();
            check({tag, "_seen"}, {31'b0, got}, 32'd1);
            if (got) begin
                check({tag, "_owner"}, {31'b0, if_valid}, {31'b0, e.is_if});
                check({tag, "_lat"}, 32'(edges), 32'(e.lat));
                if (e.chk_data) begin
                    check({tag, "_data"}, e.is_if ? if_data : ls_rdata, e.data);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_wr"},   {31'b0, ram_wr},   32'd0);
        check({tag, "_ram_addr"}, ram_addr,          32'd0);
        check({tag, "_ram_dout"}, {24'b0, ram_dout}, 32'd0);
        check({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
        check({tag, "_ls_valid"}, {31'b0, ls_valid}, 32'd0);
        check({tag, "_if_data"},  if_data,           32'd0);
        check({tag, "_ls_rdata"}, ls_rdata,          32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        poke(16'h1000, 8'h13); poke(16'h1001, 8'h05);
        poke(16'h1002, 8'h00); poke(16'h1003, 8'h00);
        poke(16'h2000, 8'hAA); poke(16'h2003, 8'h55);
        poke(16'hFFFF, 8'h11); poke(16'h0000, 8'h22);
        poke(16'h0001, 8'h33); poke(16'h0002, 8'h44);

        // fetch alone
        if_addr = 32'h1000; if_req = 1'b1;
        push_exp(1'b1, 1'b1, 32'h0000_0513, 6);
        wait_check("fetch", 20);
        if_req = 1'b0;
        @(negedge clk);

        // store half then loads of various sizes, incl. address wrap
        start_ls(1'b1, 2'd1, 32'h2001, 32'h1234_BEEF);
        push_exp(1'b0, 1'b0, 32'h0, 3);
        wait_check("st_half", 20);
        ls_req = 1'b0;
        check("st_b0", {24'b0, mem[16'h2000]}, 32'hAA);
        check("st_b1", {24'b0, mem[16'h2001]}, 32'hEF);
        check("st_b2", {24'b0, mem[16'h2002]}, 32'hBE);
        check("st_b3", {24'b0, mem[16'h2003]}, 32'h55);
        @(negedge clk);
        start_ls(1'b0, 2'd2, 32'h2000, 32'h0);
        push_exp(1'b0, 1'b1, 32'h55BE_EFAA, 6);
        wait_check("ld_word", 20);
        ls_req = 1'b0;
        @(negedge clk);
        start_ls(1'b0, 2'd0, 32'h2002, 32'h0);
        push_exp(1'b0, 1'b1, 32'h0000_00BE, 3);
        wait_check("ld_byte", 20);
        ls_req = 1'b0;
        @(negedge clk);
        start_ls(1'b0, 2'd1, 32'h2001, 32'h0);
        push_exp(1'b0, 1'b1, 32'h0000_BEEF, 4);
        wait_check("ld_half", 20);
        ls_req = 1'b0;
        @(negedge clk);
        start_ls(1'b0, 2'd3, 32'hFFFF_FFFF, 32'h0);
        push_exp(1'b0, 1'b1, 32'h4433_2211, 6);
        wait_check("ld_wrap", 20);
        ls_req = 1'b0;
        @(negedge clk);

        // simultaneous requests: LSB first, fetch at next IDLE
        start_ls(1'b0, 2'd2, 32'h2000, 32'h0);
        if_addr = 32'h1000; if_req = 1'b1;
        push_exp(1'b0, 1'b1, 32'h55BE_EFAA, 6);
        push_exp(1'b1, 1'b1, 32'h0000_0513, 7);
        wait_check("both_ls", 20);
        ls_req = 1'b0;
        wait_check("both_if", 20);
        if_req = 1'b0;
        @(negedge clk);

        // LSB held continuously alongside fetch
`ifdef ARB_STARVE_GUARD_EN
        n_ls = 4;
`else
        n_ls = 6;
`endif
        start_ls(1'b0, 2'd0, 32'h2002, 32'h0);
        if_addr = 32'h1000; if_req = 1'b1;
        push_exp(1'b0, 1'b1, 32'h0000_00BE, 3);
        wait_check("starve_ls0", 20);
        for (int i = 1; i < n_ls; i++) begin
            push_exp(1'b0, 1'b1, 32'h0000_00BE, 4);
            wait_check("starve_ls", 20);
        end
`ifdef ARB_STARVE_GUARD_EN
        push_exp(1'b1, 1'b1, 32'h0000_0513, 7);
        wait_check("starve_if", 20);
        if_req = 1'b0;
        push_exp(1'b0, 1'b1, 32'h0000_00BE, 4);
        wait_check("starve_ls_after", 20);
        ls_req = 1'b0;
`else
        ls_req = 1'b0;
        push_exp(1'b1, 1'b1, 32'h0000_0513, 7);
        wait_check("starve_if", 20);
        if_req = 1'b0;
`endif
        @(negedge clk);

        // flush at k=2 of a fetch with an LSB request pending
        if_addr = 32'h1000; if_req = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("flush_k2_addr", ram_addr, 32'h1002);
        if_flush = 1'b1;
        start_ls(1'b0, 2'd0, 32'h2003, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("flush_no_valid", {31'b0, if_valid}, 32'd0);
        check("flush_ram_wr", {31'b0, ram_wr}, 32'd0);
        if_flush = 1'b0; if_req = 1'b0;
        push_exp(1'b0, 1'b1, 32'h0000_0055, 3);
        wait_check("flush_ls", 20);
        ls_req = 1'b0;
        @(negedge clk);

        // rdy low for 3 cycles in the middle of a word store
        start_ls(1'b1, 2'd2, 32'h3000, 32'hCAFE_F00D);
        @(posedge clk);
        @(negedge clk);
        check("rdy_b0_addr", ram_addr, 32'h3000);
        check("rdy_b0_dout", {24'b0, ram_dout}, 32'h0D);
        @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rdy_hold_addr", ram_addr, 32'h3001);
            check("rdy_hold_dout", {24'b0, ram_dout}, 32'hF0);
            check("rdy_hold_wr", {31'b0, ram_wr}, 32'd1);
            check("rdy_hold_valid", {31'b0, ls_valid}, 32'd0);
        end
        rdy = 1'b1;
        push_exp(1'b0, 1'b0, 32'h0, 3);
        wait_check("rdy_store", 20);
        ls_req = 1'b0;
        check("rdy_m0", {24'b0, mem[16'h3000]}, 32'h0D);
        check("rdy_m1", {24'b0, mem[16'h3001]}, 32'hF0);
        check("rdy_m2", {24'b0, mem[16'h3002]}, 32'hFE);
        check("rdy_m3", {24'b0, mem[16'h3003]}, 32'hCA);
        @(negedge clk);

        // reset in the middle of a load
        start_ls(1'b0, 2'd2, 32'h2000, 32'h0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        ls_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if_addr = 32'h1000; if_req = 1'b1;
        push_exp(1'b1, 1'b1, 32'h0000_0513, 6);
        wait_check("post_rst_fetch", 20);
        if_req = 1'b0;
        @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
